galaxian_load_ctrl: RTL and testbench

- Sequences the download and configuration path of the Galaxian-family core.
- Routes the HPS ioctl byte stream to the program/graphics ROM write port, the game-select (mod) register and the DIP switch bank.
- Holds the core in reset during download and for a fixed settle period afterwards.
- Sits between hps_io and the galaxian core; replaces ad-hoc mod/DIP latching in the top level.

---
 rtl/galaxian_load_ctrl.sv | 130 +++++++++++++
 tb/tb_galaxian_load_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/galaxian_load_ctrl.sv
// Download/config sequencer for the Galaxian core: routes the HPS ioctl stream to
// ROM, mod and DIP targets and holds the core in reset until loading has settled.
module galaxian_load_ctrl #(
   parameter int ROM_AW        = 16,
   parameter int DIP_BYTES     = 8,
   parameter int NUM_MODS      = 18,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic                   clk_sys,
   input  logic                   reset_n,
   input  logic                   ioctl_download,
   input  logic                   ioctl_wr,
   input  logic [7:0]             ioctl_index,
   input  logic [24:0]            ioctl_addr,
   input  logic [7:0]             ioctl_dout,
   input  logic                   ext_reset,
   output logic                   rom_wr,
   output logic [ROM_AW-1:0]      rom_addr,
   output logic [7:0]             rom_data,
   output logic [NUM_MODS-1:0]    mod_onehot,
   output logic                   mod_bad,
   output logic [8*DIP_BYTES-1:0] dip_flat,
   output logic                   core_reset,
   output logic                   loaded,
   output logic                   rom_ovf
);

   localparam int CW = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [1:0] {BOOT, LOAD, SETTLE, RUN} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [7:0]    mod_reg;
   logic          acc;
   logic [31:0]   addr32;

   assign acc    = ioctl_wr & ioctl_download;
   assign addr32 = {7'd0, ioctl_addr};

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= BOOT;
         cnt        <= '0;
         core_reset <= 1'b1;
         loaded     <= 1'b0;
      end else begin
         case (state)
            BOOT: if (ioctl_download) state <= LOAD;
            LOAD: if (!ioctl_download) begin
               // The cycle that sees the fall already counts as the first settle cycle.
               if (SETTLE_CYCLES == 1) begin
                  state      <= RUN;
                  core_reset <= 1'b0;
                  loaded     <= 1'b1;
               end else begin
                  state <= SETTLE;
                  cnt   <= CW'(SETTLE_CYCLES - 2);
               end
            end
            SETTLE: begin
               if (ioctl_download)      state <= LOAD;
               else if (ext_reset)      cnt   <= CW'(SETTLE_CYCLES - 1);
               else if (cnt == '0) begin
                  state      <= RUN;
                  core_reset <= 1'b0;
                  loaded     <= 1'b1;
               end else                 cnt   <= cnt - 1'b1;
            end
            RUN: begin
               if (ioctl_download) begin
                  state      <= LOAD;
                  core_reset <= 1'b1;
                  loaded     <= 1'b0;
               end else if (ext_reset) begin
                  state      <= SETTLE;
                  cnt        <= CW'(SETTLE_CYCLES - 1);
                  core_reset <= 1'b1;
                  loaded     <= 1'b0;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         rom_wr   <= 1'b0;
         rom_addr <= '0;
         rom_data <= '0;
         rom_ovf  <= 1'b0;
      end else begin
         rom_wr <= 1'b0;
         if (acc && ioctl_index == 8'd0) begin
            if (addr32 < (32'd1 << ROM_AW)) begin
               rom_wr   <= 1'b1;
               rom_addr <= ioctl_addr[ROM_AW-1:0];
               rom_data <= ioctl_dout;
            end else begin
               rom_ovf <= 1'b1;
            end
         end
      end
   end

   // Decode is a second register stage so the mod byte path stays shallow.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         mod_reg    <= '0;
         mod_onehot <= NUM_MODS'(1);
         mod_bad    <= 1'b0;
      end else begin
         if (acc && ioctl_index == 8'd1) mod_reg <= ioctl_dout;
         for (int i = 0; i < NUM_MODS; i++)
            mod_onehot[i] <= ({24'd0, mod_reg} == 32'(i));
         mod_bad <= ({24'd0, mod_reg} >= 32'(NUM_MODS));
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dip_flat <= '1;
      end else if (acc && ioctl_index == 8'd254) begin
         for (int k = 0; k < DIP_BYTES; k++)
            if (addr32 == 32'(k)) dip_flat[8*k +: 8] <= ioctl_dout;
      end
   end

endmodule

// File: tb/tb_galaxian_load_ctrl.sv
// Scoreboarded bench for galaxian_load_ctrl: ROM writes are predicted into a queue
// and retired by a monitor; FSM, mod and DIP state are checked directly.
module tb_galaxian_load_ctrl;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        ioctl_download, ioctl_wr, ext_reset;
   logic [7:0]  ioctl_index, ioctl_dout;
   logic [24:0] ioctl_addr;
   logic        rom_wr, mod_bad, core_reset, loaded, rom_ovf;
   logic [15:0] rom_addr;
   logic [7:0]  rom_data;
   logic [17:0] mod_onehot;
   logic [63:0] dip_flat;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
      int          c;
   } rom_exp_t;

   rom_exp_t sb[$];
   int       cyc = 0;
   int       n_chk = 0;
   int       n_fail = 0;

   galaxian_load_ctrl dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
      .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .ext_reset(ext_reset), .rom_wr(rom_wr),
      .rom_addr(rom_addr), .rom_data(rom_data), .mod_onehot(mod_onehot),
      .mod_bad(mod_bad), .dip_flat(dip_flat), .core_reset(core_reset),
      .loaded(loaded), .rom_ovf(rom_ovf)
   );

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk_sys) begin
      if (rom_wr === 1'b1) begin
         if (sb.size() == 0) chk("rom_unexpected", 1, 0);
         else begin
            rom_exp_t e;
            e = sb.pop_front();
            chk("rom_addr", rom_addr, e.a);
            chk("rom_data", rom_data, e.d);
            chk("rom_lat", cyc, e.c);
         end
      end
   end

   task automatic wr_byte(input logic [7:0] idx, input logic [24:0] addr,
                          input logic [7:0] d, input bit exp_rom);
      @(posedge clk_sys); #1;
      ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = addr; ioctl_dout = d;
      if (exp_rom) sb.push_back('{addr[15:0], d, cyc + 1});
      @(posedge clk_sys); #1;
      ioctl_wr = 1'b0;
   endtask

   task automatic cnt_fall(input string tag, input int exp);
      int n = 0;
      do begin
         @(posedge clk_sys); #1;
         n++;
      end while (core_reset && n < 40);
      chk(tag, n, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int drops;
      logic [63:0] dip_exp;
      reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ext_reset = 1'b0;
      ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0;
      repeat (3) @(posedge clk_sys);
      #1 reset_n = 1'b1;
      repeat (100) @(posedge clk_sys);
      #1;
      chk("rst_core_reset", core_reset, 1);
      chk("rst_loaded", loaded, 0);
      chk("rst_mod_onehot", mod_onehot, 18'h00001);
      chk("rst_mod_bad", mod_bad, 0);
      chk("rst_dip", dip_flat, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("rst_rom_ovf", rom_ovf, 0);

      // First download: ROM bytes incl. boundaries, then mod 15
      ioctl_download = 1'b1;
      wr_byte(8'd0, 25'h0000, 8'hA5, 1);
      wr_byte(8'd0, 25'hFFFF, 8'h3C, 1);
      wr_byte(8'd0, 25'h10000, 8'h77, 0);
      @(posedge clk_sys); #1;
      chk("rom_ovf_set", rom_ovf, 1);
      chk("rom_addr_hold", rom_addr, 16'hFFFF);
      chk("rom_data_hold", rom_data, 8'h3C);
      chk("in_load_reset", core_reset, 1);
      wr_byte(8'd1, 25'h0, 8'd15, 0);
      chk("mod_lat_early", mod_onehot, 18'h00001);
      @(posedge clk_sys); #1;
      chk("mod15_onehot", mod_onehot, 18'h08000);
      chk("mod15_bad", mod_bad, 0);
      ioctl_download = 1'b0;
      cnt_fall("settle_dl1", 16);
      chk("loaded_1", loaded, 1);

      // Strobes without download must be ignored everywhere
      wr_byte(8'd0, 25'h5, 8'h11, 0);
      wr_byte(8'd1, 25'h0, 8'd3, 0);
      wr_byte(8'd254, 25'h1, 8'h22, 0);
      repeat (2) @(posedge clk_sys); #1;
      chk("nodl_mod", mod_onehot, 18'h08000);
      chk("nodl_dip", dip_flat, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("nodl_run", core_reset, 0);

      // Second download: bad mod, other index, DIP bytes
      ioctl_download = 1'b1;
      wr_byte(8'd1, 25'h7, 8'd20, 0);
      @(posedge clk_sys); #1;
      chk("mod20_onehot", mod_onehot, 18'h0);
      chk("mod20_bad", mod_bad, 1);
      chk("dl2_reset", core_reset, 1);
      wr_byte(8'd2, 25'h0, 8'hEE, 0);
      wr_byte(8'd254, 25'h2, 8'h5A, 0);
      wr_byte(8'd254, 25'h8, 8'h00, 0);
      wr_byte(8'd254, 25'h102, 8'h00, 0);
      @(posedge clk_sys); #1;
      dip_exp = 64'hFFFF_FFFF_FF5A_FFFF;
      chk("dip_write", dip_flat, dip_exp);
      chk("rom_ovf_sticky", rom_ovf, 1);
      ioctl_download = 1'b0;
      cnt_fall("settle_dl2", 16);
      chk("loaded_2", loaded, 1);

      // External reset in RUN
      ext_reset = 1'b1;
      @(posedge clk_sys); #1;
      chk("ext_rise", core_reset, 1);
      chk("ext_loaded", loaded, 0);
      repeat (2) @(posedge clk_sys);
      #1 ext_reset = 1'b0;
      cnt_fall("settle_ext", 16);

      // Download arriving mid-settle aborts the count
      ext_reset = 1'b1;
      @(posedge clk_sys);
      #1 ext_reset = 1'b0;
      repeat (10) @(posedge clk_sys);
      #1 ioctl_download = 1'b1;
      drops = 0;
      repeat (20) begin
         @(posedge clk_sys); #1;
         if (!core_reset) drops++;
      end
      chk("dl_in_settle", drops, 0);
      ioctl_download = 1'b0;
      cnt_fall("settle_dl3", 16);

      // reset_n pulse during a ROM stream
      ioctl_download = 1'b1;
      wr_byte(8'd0, 25'h1234, 8'h9C, 1);
      wr_byte(8'd254, 25'h0, 8'h12, 0);
      @(posedge clk_sys); #1;
      reset_n = 1'b0;
      #1;
      chk("prst_core_reset", core_reset, 1);
      chk("prst_loaded", loaded, 0);
      chk("prst_rom_ovf", rom_ovf, 0);
      chk("prst_dip", dip_flat, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("prst_mod", mod_onehot, 18'h00001);
      chk("prst_mod_bad", mod_bad, 0);
      chk("prst_rom_addr", rom_addr, 16'h0);
      @(posedge clk_sys);
      #1 reset_n = 1'b1;
      wr_byte(8'd0, 25'h0042, 8'h5E, 1);
      @(posedge clk_sys); #1;
      chk("prst_reload", core_reset, 1);
      ioctl_download = 1'b0;
      cnt_fall("settle_dl4", 16);
      chk("loaded_4", loaded, 1);
      chk("sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
